// File: rtl/mem_fu_sched.sv
// mem_fu_sched - shares one multi-cycle memory functional unit between two
// issue requesters. One op is accepted at a time; its operands are registered,
// a one-cycle start pulse goes to the FU, and the result (load data or store
// completion) is returned tagged with requester id and destination register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         issue handshake per requester (N = 0, 1)
//   reqN_mem_w/bhw/rs1/rs2/imm/rd   op fields per requester
//   fu_EN                    one-cycle start pulse to the memory FU
//   fu_mem_w/bhw/rs1_data/rs2_data/imm   registered operands to the FU
//   fu_finish, fu_mem_data   FU result strobe and read data
//   resp_valid/ready         response handshake to writeback
//   resp_id/rd/is_store/data response tag and payload
//   err_timeout              sticky watchdog flag
//
// Build option: define MEM_SCHED_RR_EN for round-robin arbitration between
// simultaneous requesters; otherwise req0 has fixed priority.
module mem_fu_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mem_w,
  input  logic [2:0]  req0_bhw,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [31:0] req0_imm,
  input  logic [4:0]  req0_rd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mem_w,
  input  logic [2:0]  req1_bhw,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [31:0] req1_imm,
  input  logic [4:0]  req1_rd,
  output logic        fu_EN,
  output logic        fu_mem_w,
  output logic [2:0]  fu_bhw,
  output logic [31:0] fu_rs1_data,
  output logic [31:0] fu_rs2_data,
  output logic [31:0] fu_imm,
  input  logic        fu_finish,
  input  logic [31:0] fu_mem_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [4:0]  resp_rd,
  output logic        resp_is_store,
  output logic [31:0] resp_data,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_mem_w, r_id, r_err;
  logic [2:0]  r_bhw;
  logic [31:0] r_rs1, r_rs2, r_imm, r_resp_data;
  logic [4:0]  r_rd;
  logic [3:0]  r_cnt;
  logic        w_idle, w_grant1, w_xfer, w_timeout;

  assign w_idle = (r_state == S_IDLE);

`ifdef MEM_SCHED_RR_EN
  // r_last: 1 = req1 was granted last. Resets to 1 so req0 wins the first tie.
  logic r_last;
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last);
`else
  assign w_grant1 = req1_valid & ~req0_valid;
`endif

  assign req1_ready = w_idle & w_grant1;
  assign req0_ready = w_idle & req0_valid & ~w_grant1;
  assign w_xfer     = req0_ready | req1_ready;

  // Watchdog fires on the TIMEOUT-th consecutive WAIT cycle without a finish.
  assign w_timeout = (r_state == S_WAIT) & ~fu_finish & (r_cnt == 4'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_xfer) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (fu_finish || w_timeout) w_next = S_RESP;
      S_RESP:  if (resp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mem_w     <= 1'b0;
      r_bhw       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_imm       <= '0;
      r_rd        <= '0;
      r_id        <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_resp_data <= '0;
`ifdef MEM_SCHED_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_mem_w <= w_grant1 ? req1_mem_w : req0_mem_w;
        r_bhw   <= w_grant1 ? req1_bhw   : req0_bhw;
        r_rs1   <= w_grant1 ? req1_rs1   : req0_rs1;
        r_rs2   <= w_grant1 ? req1_rs2   : req0_rs2;
        r_imm   <= w_grant1 ? req1_imm   : req0_imm;
        r_rd    <= w_grant1 ? req1_rd    : req0_rd;
        r_id    <= w_grant1;
`ifdef MEM_SCHED_RR_EN
        r_last  <= w_grant1;
`endif
      end
      if (r_state == S_ISSUE) r_cnt <= '0;
      if (r_state == S_WAIT) begin
        if (fu_finish) begin
          r_resp_data <= r_mem_w ? 32'd0 : fu_mem_data;
        end else if (w_timeout) begin
          r_resp_data <= 32'd0;
          r_err       <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  // Operand and tag outputs come straight from the latched registers, so they
  // hold from acceptance until the next acceptance.
  assign fu_EN         = (r_state == S_ISSUE);
  assign fu_mem_w      = r_mem_w;
  assign fu_bhw        = r_bhw;
  assign fu_rs1_data   = r_rs1;
  assign fu_rs2_data   = r_rs2;
  assign fu_imm        = r_imm;
  assign resp_valid    = (r_state == S_RESP);
  assign resp_id       = r_id;
  assign resp_rd       = r_rd;
  assign resp_is_store = r_mem_w;
  assign resp_data     = r_resp_data;
  assign err_timeout   = r_err;

endmodule
